// File: rtl/result_reporter.sv
// result_reporter: UART (8N1) reporter for the MD5 search driver.
// Sends one found/not-found report on the rising edge of status_done, and
// optional periodic progress reports carrying the current target while running.
module result_reporter #(
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned PROGRESS_CYCLES = 100000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] target,
  input  logic        status_running,
  input  logic        status_found,
  input  logic        status_done,
  output logic        uart_txd,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, NEXT} state_t;
  typedef enum logic [1:0] {MSG_FOUND, MSG_NOTFOUND, MSG_PROGRESS} msg_t;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // NEXT and LOAD each take one clock of the stop bit, so STOP itself is
  // two clocks shorter; this keeps bytes back-to-back with no idle gap.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 3);
  localparam bit            PROG_EN   = (PROGRESS_CYCLES != 0);
  localparam logic [31:0]   PC_LAST   = PROG_EN ? 32'(PROGRESS_CYCLES - 1) : '0;

  state_t        state;
  msg_t          cur_kind;
  logic [31:0]   cur_snap;
  logic          pend;
  logic [31:0]   pend_snap;
  logic          pend_found;
  logic [3:0]    idx;
  logic [3:0]    last_idx;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    nbit;
  logic [7:0]    shreg;
  logic [7:0]    cur_byte;
  logic          done_q;
  logic          done_trig;
  logic [31:0]   prog_cnt;
  logic          prog_run;
  logic          tick;

  assign done_trig = status_done & ~done_q;
  assign prog_run  = PROG_EN & status_running & ~status_done;
  assign tick      = prog_run && (prog_cnt == PC_LAST);

  // Previous-cycle copy of status_done for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= status_done;
  end

  // Progress interval counter: runs only while searching, wraps at each tick.
  always_ff @(posedge CLK) begin
    if (reset)         prog_cnt <= '0;
    else if (prog_run) prog_cnt <= (prog_cnt == PC_LAST) ? '0 : prog_cnt + 32'd1;
    else               prog_cnt <= '0;
  end

  // Select the ASCII byte at position idx of the current message.
  always_comb begin
    logic [31:0] sh;
    logic [3:0]  nib;
    sh       = cur_snap << {idx - 4'd2, 2'b00};
    nib      = sh[31:28];
    cur_byte = '0;
    last_idx = (cur_kind == MSG_NOTFOUND) ? 4'd2 : 4'd11;
    if (cur_kind == MSG_NOTFOUND) begin
      case (idx)
        4'd0:    cur_byte = 8'h4E;
        4'd1:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      case (idx)
        4'd0:    cur_byte = (cur_kind == MSG_FOUND) ? 8'h46 : 8'h50;
        4'd1:    cur_byte = 8'h3A;
        4'd10:   cur_byte = 8'h0D;
        4'd11:   cur_byte = 8'h0A;
        default: cur_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
      endcase
    end
  end

  // Message sequencer and UART transmitter with registered line and busy.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      uart_txd   <= 1'b1;
      busy       <= 1'b0;
      pend       <= 1'b0;
      pend_snap  <= '0;
      pend_found <= 1'b0;
      cur_kind   <= MSG_NOTFOUND;
      cur_snap   <= '0;
      idx        <= '0;
      bit_cnt    <= '0;
      nbit       <= '0;
      shreg      <= '0;
    end else begin
      if (done_trig && state != IDLE) begin
        pend       <= 1'b1;
        pend_snap  <= target;
        pend_found <= status_found;
      end
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          uart_txd <= 1'b1;
          idx      <= '0;
          if (done_trig) begin
            cur_snap <= target;
            cur_kind <= status_found ? MSG_FOUND : MSG_NOTFOUND;
            state    <= LOAD;
          end else if (tick && !busy) begin
            cur_snap <= target;
            cur_kind <= MSG_PROGRESS;
            state    <= LOAD;
          end
        end
        LOAD: begin
          shreg    <= cur_byte;
          uart_txd <= 1'b0;
          busy     <= 1'b1;
          bit_cnt  <= '0;
          state    <= START;
        end
        START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            uart_txd <= shreg[0];
            shreg    <= shreg >> 1;
            nbit     <= '0;
            state    <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (nbit == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              uart_txd <= shreg[0];
              shreg    <= shreg >> 1;
              nbit     <= nbit + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt <= '0;
            state   <= NEXT;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx != last_idx) begin
            idx   <= idx + 4'd1;
            state <= LOAD;
          end else if (pend) begin
            pend     <= 1'b0;
            cur_snap <= pend_snap;
            cur_kind <= pend_found ? MSG_FOUND : MSG_NOTFOUND;
            idx      <= '0;
            state    <= LOAD;
          end else if (done_trig) begin
            // Trigger landing in this very cycle is taken directly.
            pend     <= 1'b0;
            cur_snap <= target;
            cur_kind <= status_found ? MSG_FOUND : MSG_NOTFOUND;
            idx      <= '0;
            state    <= LOAD;
          end else begin
            // busy stays high through the final stop-bit clock spent in IDLE.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_reporter.sv
// Directed testbench for result_reporter with CLKS_PER_BIT=4, PROGRESS_CYCLES=1000.
module tb_result_reporter;

  localparam int unsigned CPB = 4;
  localparam int unsigned PC  = 1000;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] target;
  logic        status_running;
  logic        status_found;
  logic        status_done;
  logic        uart_txd;
  logic        busy;

  result_reporter #(.CLKS_PER_BIT(CPB), .PROGRESS_CYCLES(PC)) dut (
    .CLK(CLK),
    .reset(reset),
    .target(target),
    .status_running(status_running),
    .status_found(status_found),
    .status_done(status_done),
    .uart_txd(uart_txd),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic       inc_en   = 1'b0;
  logic [7:0] exp_b [12];
  int         first_st, last_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    if (inc_en) target = target + 32'd1;
  endtask

  function automatic void build_hex(input logic [7:0] lead, input logic [31:0] v);
    logic [3:0] n;
    exp_b[0] = lead;
    exp_b[1] = 8'h3A;
    for (int i = 0; i < 8; i++) begin
      n = v[(7-i)*4 +: 4];
      exp_b[2+i] = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    end
    exp_b[10] = 8'h0D;
    exp_b[11] = 8'h0A;
  endfunction

  task automatic rx_byte(input logic [7:0] exp, input string tag, output int st);
    int guard;
    logic [7:0] d;
    guard = 0;
    while (uart_txd !== 1'b0 && guard < 3000) begin step(); guard++; end
    chk({tag, " timeout"}, 32'(guard < 3000), 32'd1);
    st = cyc;
    repeat (2) step();
    chk({tag, " start"}, 32'(uart_txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      d[i] = uart_txd;
    end
    repeat (4) step();
    chk({tag, " stop"}, 32'(uart_txd), 32'd1);
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic rx_msg(input int n, input string tag);
    int st;
    for (int i = 0; i < n; i++) begin
      rx_byte(exp_b[i], $sformatf("%s byte%0d", tag, i), st);
      if (i == 0) first_st = st;
      last_st = st;
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin step(); guard++; end
    chk({tag, " idle timeout"}, 32'(guard < 3000), 32'd1);
  endtask

  initial begin
    int c0, p1, p2, st, q, guard;
    reset = 1'b1; target = '0; status_running = 1'b0; status_found = 1'b0; status_done = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 10; i++) begin
      target = $urandom;
      status_running = i[0];
      status_done    = i[1];
      status_found   = i[2];
      step();
      chk("reset txd", 32'(uart_txd), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
    end
    target = '0; status_running = 1'b0; status_done = 1'b0; status_found = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Found report with trigger latency
    target = 32'h1234ABC8; status_found = 1'b1; status_done = 1'b1;
    step();
    chk("found busy k+1", 32'(busy), 32'd0);
    step();
    chk("found busy k+2", 32'(busy), 32'd1);
    chk("found txd k+2", 32'(uart_txd), 32'd0);
    exp_b = '{8'h46, 8'h3A, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h38, 8'h0D, 8'h0A};
    rx_msg(12, "found");
    wait_idle("found");
    chk("found busy cycles", 32'(cyc - first_st), 32'd480);

    // Not-found report
    status_done = 1'b0; status_found = 1'b0;
    repeat (3) step();
    status_done = 1'b1;
    exp_b[0] = 8'h4E; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
    rx_msg(3, "notfound");
    wait_idle("notfound");
    chk("notfound busy cycles", 32'(cyc - first_st), 32'd120);

    // Done held: no repeat report
    q = 0;
    repeat (600) begin
      step();
      if (uart_txd !== 1'b1 || busy !== 1'b0) q++;
    end
    chk("done held quiet", 32'(q), 32'd0);
    status_done = 1'b0;
    repeat (3) step();

    // Progress reports with incrementing target
    target = 32'h0000FF00; status_running = 1'b1; inc_en = 1'b1;
    c0 = cyc;
    build_hex(8'h50, 32'h000102E7);
    rx_msg(12, "prog1");
    p1 = first_st;
    chk("prog1 start time", 32'(p1 - c0), 32'd1001);

    // Second progress report; done rises during it
    build_hex(8'h50, 32'h000106CF);
    p2 = 0;
    for (int i = 0; i < 12; i++) begin
      rx_byte(exp_b[i], $sformatf("prog2 byte%0d", i), st);
      if (i == 0) p2 = st;
      if (i == 2) begin
        inc_en = 1'b0; target = 32'hDEADBEEF; status_found = 1'b1; status_done = 1'b1;
      end
      last_st = st;
    end
    chk("prog period", 32'(p2 - p1), 32'd1000);
    c0 = last_st;
    build_hex(8'h46, 32'hDEADBEEF);
    rx_msg(12, "found2");
    chk("pending found gap", 32'(first_st - c0), 32'd40);
    wait_idle("found2");

    // Reset in the middle of byte 3
    status_running = 1'b0; status_done = 1'b0; status_found = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    target = 32'h00C0FFEE; status_found = 1'b1; status_done = 1'b1;
    build_hex(8'h46, 32'h00C0FFEE);
    rx_msg(3, "abort");
    guard = 0;
    while (uart_txd !== 1'b0 && guard < 100) begin step(); guard++; end
    chk("abort byte3 start", 32'(guard < 100), 32'd1);
    repeat (10) step();
    reset = 1'b1; status_done = 1'b0; status_found = 1'b0;
    step();
    chk("abort txd", 32'(uart_txd), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    q = 0;
    repeat (300) begin
      step();
      if (uart_txd !== 1'b1 || busy !== 1'b0) q++;
    end
    chk("after abort quiet", 32'(q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
